operand_issue_queue: RTL and testbench

In-order issue buffer between pre-decode (IPD) and execute (EXE) that generalises the decode-stage operand collection. It holds up to DEPTH decoded instructions. For the head entry it resolves NSRC source operands from NBYP bypass stages or the register file. It issues the head to EXE once every operand is ready, and it flushes completely on branch mispredict. It also exports occupancy and a saturating operand-stall counter for performance monitoring.

---
 rtl/operand_issue_queue.sv | 149 ++++++++++++++
 tb/tb_operand_issue_queue.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_issue_queue.sv
// In-order issue buffer between pre-decode and execute.
// Holds up to DEPTH decoded instructions. The head entry's source operands are
// resolved from the bypass network (youngest stage first) or the register file.
// The head issues once every operand is ready. Flush empties the queue, and a
// saturating counter records the cycles spent waiting on operands.
module operand_issue_queue #(
    parameter int DEPTH = 4,
    parameter int NSRC  = 2,
    parameter int NBYP  = 4,
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int PW    = 128
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PW-1:0]             in_payload,
    input  logic [NSRC*AW-1:0]        in_src_addr,
    input  logic [NSRC-1:0]           in_src_use,
    input  logic                      flush,
    input  logic [NBYP*AW-1:0]        byp_addr,
    input  logic [NBYP*DW-1:0]        byp_data,
    input  logic [NBYP-1:0]           byp_wen,
    input  logic [NBYP-1:0]           byp_valid,
    input  logic [NBYP-1:0]           byp_data_ok,
    output logic [NSRC*AW-1:0]        rf_raddr,
    input  logic [NSRC*DW-1:0]        rf_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PW-1:0]             out_payload,
    output logic [NSRC*DW-1:0]        out_src,
    output logic [$clog2(DEPTH):0]    count,
    output logic [31:0]               stall_cycles
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);

    logic [PW-1:0]      payload_q [DEPTH];
    logic [NSRC*AW-1:0] addr_q    [DEPTH];
    logic [NSRC-1:0]    use_q     [DEPTH];

    logic [PTRW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     stall_q, stall_d;

    logic [NSRC-1:0] src_rdy;
    logic            all_rdy;
    logic            not_empty;
    logic            enq;
    logic            deq;

    assign not_empty    = (count_q != '0);
    assign all_rdy      = &src_rdy;
    assign in_ready     = ~reset & ~flush & (count_q != FULL_CNT);
    assign out_valid    = not_empty & all_rdy & ~flush & ~reset;
    assign enq          = in_valid & in_ready;
    assign deq          = out_valid & out_ready;
    assign rf_raddr     = addr_q[rp_q];
    assign out_payload  = payload_q[rp_q];
    assign count        = count_q;
    assign stall_cycles = stall_q;

    // Resolve each head source: r0/unused -> 0, first bypass hit wins, else register file.
    always_comb begin
        logic [AW-1:0] a;
        logic [DW-1:0] val;
        logic          found;
        src_rdy = '1;
        out_src = '0;
        for (int s = 0; s < NSRC; s++) begin
            a     = addr_q[rp_q][s*AW +: AW];
            val   = '0;
            found = 1'b0;
            if (use_q[rp_q][s] && (a != '0)) begin
                for (int i = 0; i < NBYP; i++) begin
                    if (!found && (byp_addr[i*AW +: AW] == a) && byp_wen[i] && byp_valid[i]) begin
                        found = 1'b1;
                        if (byp_data_ok[i]) begin
                            val = byp_data[i*DW +: DW];
                        end else begin
                            src_rdy[s] = 1'b0;
                        end
                    end
                end
                if (!found) begin
                    val = rf_rdata[s*DW +: DW];
                end
            end
            out_src[s*DW +: DW] = src_rdy[s] ? val : '0;
        end
    end

    // Next-state for pointers, occupancy and the stall counter; flush overrides traffic.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        stall_d = stall_q;
        if (enq) begin
            wp_d = wp_q + PTR_ONE;
        end
        if (deq) begin
            rp_d = rp_q + PTR_ONE;
        end
        if (enq && !deq) begin
            count_d = count_q + CNT_ONE;
        end else if (!enq && deq) begin
            count_d = count_q - CNT_ONE;
        end
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end
        if (not_empty && !all_rdy && !flush && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    // Entry storage written at the write pointer; contents are never cleared.
    always_ff @(posedge clk) begin
        if (enq) begin
            payload_q[wp_q] <= in_payload;
            addr_q[wp_q]    <= in_src_addr;
            use_q[wp_q]     <= in_src_use;
        end
    end

endmodule

// File: tb/tb_operand_issue_queue.sv
// Scoreboard bench for operand_issue_queue: directed stimulus pushes expected
// issues into a queue, and a monitor compares each issued instruction.
module tb_operand_issue_queue;

    localparam int DEPTH = 4;
    localparam int NSRC  = 2;
    localparam int NBYP  = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int PW    = 128;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [PW-1:0]          in_payload;
    logic [NSRC*AW-1:0]     in_src_addr;
    logic [NSRC-1:0]        in_src_use;
    logic                   flush;
    logic [NBYP*AW-1:0]     byp_addr;
    logic [NBYP*DW-1:0]     byp_data;
    logic [NBYP-1:0]        byp_wen;
    logic [NBYP-1:0]        byp_valid;
    logic [NBYP-1:0]        byp_data_ok;
    logic [NSRC*AW-1:0]     rf_raddr;
    logic [NSRC*DW-1:0]     rf_rdata;
    logic                   out_valid;
    logic                   out_ready;
    logic [PW-1:0]          out_payload;
    logic [NSRC*DW-1:0]     out_src;
    logic [$clog2(DEPTH):0] count;
    logic [31:0]            stall_cycles;

    operand_issue_queue #(
        .DEPTH(DEPTH), .NSRC(NSRC), .NBYP(NBYP), .DW(DW), .AW(AW), .PW(PW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .in_src_addr(in_src_addr), .in_src_use(in_src_use), .flush(flush),
        .byp_addr(byp_addr), .byp_data(byp_data), .byp_wen(byp_wen),
        .byp_valid(byp_valid), .byp_data_ok(byp_data_ok),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .out_src(out_src), .count(count), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] p;
        logic [DW-1:0] s0;
        logic [DW-1:0] s1;
    } exp_t;

    exp_t sb[$];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    // Register file model: distinctive value per register number.
    function automatic logic [DW-1:0] rfv(input logic [AW-1:0] a);
        return {16'hC0DE, 11'b0, a};
    endfunction

    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            rf_rdata[s*DW +: DW] = rfv(rf_raddr[s*AW +: AW]);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every issue handshake is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL unexpected_issue: got payload %h expected no issue", out_payload);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("issue_payload", 128'(out_payload), 128'(e.p));
                check("issue_src0", 128'(out_src[0 +: DW]), 128'(e.s0));
                check("issue_src1", 128'(out_src[DW +: DW]), 128'(e.s1));
            end
        end
    end

    task automatic set_byp(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic wen, input logic vld, input logic ok);
        byp_addr[i*AW +: AW] = a;
        byp_data[i*DW +: DW] = d;
        byp_wen[i]           = wen;
        byp_valid[i]         = vld;
        byp_data_ok[i]       = ok;
    endtask

    task automatic clr_byp();
        byp_addr    = '0;
        byp_data    = '0;
        byp_wen     = '0;
        byp_valid   = '0;
        byp_data_ok = '0;
    endtask

    // Offer one instruction, expect acceptance, and optionally record its expected issue.
    task automatic push(input logic [31:0] tag, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic u0, input logic u1, input logic [DW-1:0] e0,
                        input logic [DW-1:0] e1, input logic exp_en);
        exp_t e;
        in_valid    = 1'b1;
        in_payload  = {96'h0, tag};
        in_src_addr = {a1, a0};
        in_src_use  = {u1, u0};
        if (exp_en) begin
            e.p  = {96'h0, tag};
            e.s0 = e0;
            e.s1 = e1;
            sb.push_back(e);
        end
        @(negedge clk);
        check("push_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_payload  = '0;
        in_src_addr = '0;
        in_src_use  = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        clr_byp();

        // Reset behaviour
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 128'(in_ready), 128'(0));
        check("reset_out_valid", 128'(out_valid), 128'(0));
        reset = 1'b0;
        #1;
        check("reset_count", 128'(count), 128'(0));
        check("reset_stall", 128'(stall_cycles), 128'(0));
        check("idle_in_ready", 128'(in_ready), 128'(1));

        // Back-to-back independent instructions, one issue per cycle
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push(32'hA000 + k, AW'(k + 1), AW'(k + 9), 1'b1, 1'b1,
                 rfv(AW'(k + 1)), rfv(AW'(k + 9)), 1'b1);
            if (k == 0) check("b2b_first_valid", 128'(out_valid), 128'(1));
            check("b2b_count", 128'(count), 128'(1));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_drained", 128'(count), 128'(0));

        // Forward priority: youngest matching stage wins
        out_ready = 1'b0;
        push(32'hB000, 5'd5, 5'd6, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1);
        in_valid = 1'b0;
        set_byp(0, 5'd5, 32'h11, 1'b1, 1'b1, 1'b1);
        set_byp(1, 5'd6, 32'h22, 1'b1, 1'b1, 1'b1);
        set_byp(3, 5'd5, 32'h44, 1'b1, 1'b1, 1'b1);
        #1;
        check("fwd_stage0", 128'(out_src[0 +: DW]), 128'(32'h11));
        check("fwd_unused_src1", 128'(out_src[DW +: DW]), 128'(0));
        check("fwd_valid", 128'(out_valid), 128'(1));
        byp_wen[0] = 1'b0;
        #1;
        check("fwd_stage3", 128'(out_src[0 +: DW]), 128'(32'h44));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clr_byp();
        check("fwd_drained", 128'(count), 128'(0));

        // Load-use stall: hit with data not yet available
        set_byp(0, 5'd7, 32'hDEAD, 1'b1, 1'b1, 1'b0);
        set_byp(2, 5'd7, 32'h7777, 1'b1, 1'b1, 1'b1);
        push(32'hC000, 5'd7, 5'd3, 1'b1, 1'b1, 32'hABCD, rfv(5'd3), 1'b1);
        in_valid = 1'b0;
        check("lu_stall1_valid", 128'(out_valid), 128'(0));
        check("lu_stall1_src0", 128'(out_src[0 +: DW]), 128'(0));
        @(posedge clk);
        #1;
        check("lu_stall2_valid", 128'(out_valid), 128'(0));
        @(posedge clk);
        #1;
        set_byp(0, 5'd7, 32'hABCD, 1'b1, 1'b1, 1'b1);
        #1;
        check("lu_stall_count", 128'(stall_cycles), 128'(2));
        check("lu_release_valid", 128'(out_valid), 128'(1));
        @(posedge clk);
        #1;
        clr_byp();
        check("lu_drained", 128'(count), 128'(0));

        // r0 and unused source read as zero, never forwarded
        set_byp(0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        set_byp(1, 5'd9, 32'h9999, 1'b1, 1'b1, 1'b0);
        push(32'hD000, 5'd0, 5'd9, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        in_valid = 1'b0;
        check("r0_valid", 128'(out_valid), 128'(1));
        check("r0_src", 128'(out_src), 128'(0));
        @(posedge clk);
        #1;
        clr_byp();
        check("r0_drained", 128'(count), 128'(0));

        // Full, then wrap the pointers
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push(32'hE000 + k, AW'(k + 20), AW'(k + 24), 1'b1, 1'b1,
                 rfv(AW'(k + 20)), rfv(AW'(k + 24)), 1'b1);
        end
        check("full_in_ready", 128'(in_ready), 128'(0));
        check("full_count", 128'(count), 128'(4));
        in_payload  = {96'h0, 32'hE004};
        in_src_addr = {5'd28, 5'd24};
        out_ready   = 1'b1;
        #1;
        check("full_deq_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        check("full_after_deq", 128'(count), 128'(3));
        for (int k = 4; k < 10; k++) begin
            push(32'hE000 + k, AW'(k + 20), AW'(k + 14), 1'b1, 1'b1,
                 rfv(AW'(k + 20)), rfv(AW'(k + 14)), 1'b1);
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("wrap_drained", 128'(count), 128'(0));
        check("wrap_sb_empty", 128'(sb.size()), 128'(0));

        // Flush with a pending offer
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push(32'hF000 + k, AW'(k + 1), AW'(k + 2), 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
        end
        in_valid   = 1'b1;
        in_payload = {96'h0, 32'hF0FF};
        flush      = 1'b1;
        out_ready  = 1'b1;
        #1;
        check("flush_count_before", 128'(count), 128'(3));
        check("flush_in_ready", 128'(in_ready), 128'(0));
        check("flush_out_valid", 128'(out_valid), 128'(0));
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_count_after", 128'(count), 128'(0));
        check("flush_out_valid_after", 128'(out_valid), 128'(0));
        check("flush_stall_kept", 128'(stall_cycles), 128'(2));
        repeat (4) @(posedge clk);
        #1;
        check("flush_stays_empty", 128'(count), 128'(0));

        // Reset mid-operation clears the stall counter
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset2_stall", 128'(stall_cycles), 128'(0));
        check("final_sb_empty", 128'(sb.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
